// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I load/store funct3 encodings
//   - lsu_state_t : sequencing states of load_store_unit
//   - lsu_size_t  : access width decoded from funct3[1:0]
//   - size_bytes(), size_mask(), load_extend() helpers
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } lsu_size_t;

    function automatic logic [2:0] size_bytes(input lsu_size_t size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    // Byte-lane mask of an access that starts at lane 0.
    function automatic logic [3:0] size_mask(input lsu_size_t size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    // funct3[2] selects zero-extension; otherwise sign-extend from the access width.
    function automatic logic [31:0] load_extend(input logic [31:0] data, input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return funct3[2] ? {24'd0, data[7:0]}  : {{24{data[7]}}, data[7:0]};
            2'b01:   return funct3[2] ? {16'd0, data[15:0]} : {{16{data[15]}}, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Combinational lane alignment for one memory word of an access.
//   offset      : byte offset of the access inside its first word
//   access_mask : size mask of the access, starting at lane 0
//   hi_half     : 0 = first (low) word, 1 = second word of a split access
//   store_data  : right-justified store data
//   load_word   : raw word read from memory
//   byte_en     : lanes of this word touched by the access
//   store_lanes : store data moved onto its memory lanes
//   load_part   : captured lanes moved to their position in the load result
// -----------------------------------------------------------------------------
module lsu_lane_align (
    input  logic [1:0]  offset,
    input  logic [3:0]  access_mask,
    input  logic        hi_half,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_part
);

    logic [4:0]  lo_shift;   // 8*o
    logic [5:0]  hi_shift;   // 8*(4-o); 32 when o = 0, which shifts everything out
    logic [2:0]  hi_lanes;   // 4-o
    logic [31:0] lane_bits;

    assign lo_shift = {offset, 3'b000};
    assign hi_shift = 6'd32 - {1'b0, offset, 3'b000};
    assign hi_lanes = 3'd4 - {1'b0, offset};

    // NOTE: every signal gets a default at the top of an always_comb, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_en     = '0;
        store_lanes = '0;
        load_part   = '0;
        lane_bits   = '0;

        if (hi_half) begin
            byte_en     = access_mask >> hi_lanes;
            store_lanes = store_data >> hi_shift;
        end else begin
            byte_en     = access_mask << offset;   // lanes past 3 belong to the next word
            store_lanes = store_data << lo_shift;
        end

        for (int k = 0; k < 4; k++) begin
            lane_bits[8*k +: 8] = {8{byte_en[k]}};
        end

        // Only lanes belonging to this access contribute to the load result.
        if (hi_half) begin
            load_part = (load_word & lane_bits) << hi_shift;
        end else begin
            load_part = (load_word & lane_bits) >> lo_shift;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Executes one load/store at a time between the execute stage and a
// byte-addressable data memory. Word-crossing accesses take two memory cycles.
//   clk, reset          : clock, asynchronous active-high reset
//   req_*               : request handshake (is_store, funct3, address, wdata)
//   resp_*              : response handshake (extended load data, fault flag)
//   mem_address         : word-aligned byte address
//   mem_wdata           : lane-positioned store data
//   mem_read_byte_en    : read lane enables
//   mem_write_byte_en   : write lane enables
//   mem_rdata           : combinational read data from memory
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_read_byte_en,
    output logic [3:0]  mem_write_byte_en,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;

    // Captured request
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    lsu_size_t   size_q;
    logic        split_q;
    logic [31:0] load_lo_q;   // low-word contribution of a split load

    // Request decode
    lsu_size_t   req_size;
    logic        req_legal;
    logic        req_fault;
    logic        req_split;
    logic [32:0] last_byte;

    // Alignment datapath
    logic        hi_half;
    logic        in_access;
    logic [31:0] word_address;
    logic [3:0]  lane_en;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    always_comb begin
        req_size  = SIZE_WORD;
        req_legal = 1'b0;
        case (req_funct3[1:0])
            2'b00:   req_size = SIZE_BYTE;
            2'b01:   req_size = SIZE_HALF;
            default: req_size = SIZE_WORD;
        endcase

        if (req_is_store) begin
            req_legal = req_funct3 inside {F3_SB, F3_SH, F3_SW};
        end else begin
            req_legal = req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end

        // 33 bits wide so an access wrapping past 0xFFFFFFFF is out of range too.
        last_byte = {1'b0, req_address} + {30'd0, size_bytes(req_size)} - 33'd1;
        req_fault = !req_legal || (last_byte >= 33'(MEM_SIZE));
        req_split = ({1'b0, req_address[1:0]} + size_bytes(req_size)) > 3'd4;
    end

    assign word_address = {addr_q[31:2], 2'b00};
    assign hi_half      = (state == ACC_HI);
    assign in_access    = (state == ACC_LO) || hi_half;

    lsu_lane_align u_lane_align (
        .offset      (addr_q[1:0]),
        .access_mask (size_mask(size_q)),
        .hi_half     (hi_half),
        .store_data  (wdata_q),
        .load_word   (mem_rdata),
        .byte_en     (lane_en),
        .store_lanes (lane_wdata),
        .load_part   (lane_rdata)
    );

    // Memory side is decoded from the state register, so an asynchronous
    // reset drops the enables immediately instead of at the next edge.
    always_comb begin
        mem_address       = '0;
        mem_wdata         = '0;
        mem_read_byte_en  = '0;
        mem_write_byte_en = '0;
        if (in_access) begin
            mem_address = hi_half ? word_address + 32'd4 : word_address;
            if (is_store_q) begin
                mem_wdata         = lane_wdata;
                mem_write_byte_en = lane_en;
            end else begin
                mem_read_byte_en  = lane_en;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SIZE_BYTE;
            split_q    <= 1'b0;
            load_lo_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        addr_q     <= req_address;
                        wdata_q    <= req_wdata;
                        size_q     <= req_size;
                        split_q    <= req_split;
                        req_ready  <= 1'b0;
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= ACC_LO;
                        end
                    end
                end

                ACC_LO: begin
                    load_lo_q <= lane_rdata;
                    if (split_q) begin
                        state <= ACC_HI;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= is_store_q ? 32'd0 : load_extend(lane_rdata, funct3_q);
                    end
                end

                ACC_HI: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rdata <= is_store_q ? 32'd0 : load_extend(load_lo_q | lane_rdata, funct3_q);
                end

                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_fault <= 1'b0;
                        resp_rdata <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
